channel_bank: RTL
=================

CHANNEL_BANK -- requirements
Module: channel_bank

Interface
REQ-001 SHALL have parameter data_width, default 16, channel sample width in bits (signed).
REQ-002 SHALL have parameter full_width, default 2*data_width+8, accumulator width in bits (signed).
REQ-003 SHALL have parameter n_channels, fixed at 16, number of channel registers (address width 4).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  qualifies every state update except reset.
REQ-007 SHALL have port sample_tick  input  1  one-cycle pulse, start of a new audio sample period.
REQ-008 SHALL have port channel_write_addr  input  4  target channel of a write.
REQ-009 SHALL have port channel_write_val  input  data_width  signed write data.
REQ-010 SHALL have port channel_write_enable  input  1  commit a channel write this cycle.
REQ-011 SHALL have port accumulator_write_val  input  full_width  signed accumulator data.
REQ-012 SHALL have port accumulator_write_enable  input  1  commit an accumulator update this cycle.
REQ-013 SHALL have port accumulator_add_enable  input  1  1 = add to accumulator, 0 = overwrite; used only with write enable.
REQ-014 SHALL have ports read_addr_a, read_addr_b  input  4 each  operand fetch addresses.
REQ-015 SHALL have ports read_val_a, read_val_b  output  data_width each  registered signed operand data.
REQ-016 SHALL have port acc_shift  input  5  arithmetic right-shift applied on accumulator readout, 0..31.
REQ-017 SHALL have port acc_read_val  output  data_width  registered saturated accumulator readout.
REQ-018 SHALL have port out_channel  input  4  channel emitted as the output sample.
REQ-019 SHALL have ports sample_out  output  data_width  and  sample_out_valid  output  1  output sample and its one-cycle strobe.

Function
REQ-020 SHALL hold 16 signed data_width channel registers and one signed full_width accumulator.
REQ-021 SHALL, when enable and channel_write_enable, load channel[channel_write_addr] with channel_write_val at the clock edge.
REQ-022 SHALL, when enable and accumulator_write_enable and not accumulator_add_enable, load accumulator with accumulator_write_val.
REQ-023 SHALL, when enable and both accumulator enables, load accumulator with accumulator + accumulator_write_val, saturated to [-2^(full_width-1), 2^(full_width-1)-1]; no wrap-around.
REQ-024 SHALL ignore accumulator_add_enable when accumulator_write_enable is low.
REQ-025 SHALL register read_val_a/b one cycle after address presentation (latency 1) while enable is high; hold previous values while enable is low.
REQ-026 SHALL bypass: if a channel write to the same address commits in the cycle the read address is sampled, read_val returns the new write value.
REQ-027 SHALL allow read_addr_a == read_addr_b; both outputs carry identical data.
REQ-028 SHALL compute acc_read_val each enabled cycle as (accumulator >>> acc_shift) saturated to data_width signed range, registered, latency 1 from the accumulator state; the bypass of REQ-026 applies analogously to same-cycle accumulator updates.
REQ-029 SHALL, on enable and sample_tick, load sample_out with channel[out_channel] as held before that edge (a same-cycle write to out_channel is not visible) and pulse sample_out_valid high for exactly one cycle.
REQ-030 SHALL keep sample_out_valid low in every cycle not following an enabled sample_tick.
REQ-031 SHALL process a channel write and an accumulator update in the same cycle independently.
REQ-032 SHALL, with enable low, change no channel, accumulator or output register; sample_tick during enable low is dropped.

Reset
REQ-033 SHALL, on reset assertion, asynchronously clear all channels, accumulator, read_val_a/b, acc_read_val and sample_out to 0 and sample_out_valid to 0.
REQ-034 SHALL, with reset high, ignore all write, tick and read inputs; first update occurs on the first rising edge after reset deasserts.
REQ-035 SHALL, if reset asserts mid-period, lose all channel and accumulator contents; no partial write survives.

Verification
REQ-036 Write ch3=0x1234, next cycle read_addr_a=3 -> read_val_a=0x1234 one cycle later; same-cycle write ch5=0x0042 with read_addr_b=5 -> read_val_b=0x0042 (bypass).
REQ-037 Overwrite acc=100 then add 23, add -200 -> accumulator -77; acc_shift=0 -> acc_read_val=-77 (0xFFB3).
REQ-038 Overwrite acc=2^39-1 then add 1 -> accumulator stays 2^39-1; acc_shift=8 -> acc_read_val=0x7FFF (saturated).
REQ-039 ch2=0x0100, out_channel=2, sample_tick with simultaneous write ch2=0x0200 -> sample_out=0x0100, sample_out_valid high one cycle, ch2 reads 0x0200 afterwards.
REQ-040 enable=0 with writes and sample_tick -> no state change, sample_out_valid stays 0.
REQ-041 Load ch7=0x7FFF and acc=5, assert reset mid-cycle -> all outputs 0 immediately (asynchronous), ch7 and accumulator read 0 after release.

Source files
------------

// File: rtl/channel_bank.sv
// rtl/channel_bank.sv - sixteen-channel sample register bank with saturating accumulator
// Registered operand reads with write bypass, shifted/saturated accumulator readout, sample output strobe.
module channel_bank #(
    parameter int data_width = 16,
    parameter int full_width = 2 * data_width + 8,
    parameter int n_channels = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sample_tick,
    input  logic [3:0]            channel_write_addr,
    input  logic [data_width-1:0] channel_write_val,
    input  logic                  channel_write_enable,
    input  logic [full_width-1:0] accumulator_write_val,
    input  logic                  accumulator_write_enable,
    input  logic                  accumulator_add_enable,
    input  logic [3:0]            read_addr_a,
    input  logic [3:0]            read_addr_b,
    output logic [data_width-1:0] read_val_a,
    output logic [data_width-1:0] read_val_b,
    input  logic [4:0]            acc_shift,
    output logic [data_width-1:0] acc_read_val,
    input  logic [3:0]            out_channel,
    output logic [data_width-1:0] sample_out,
    output logic                  sample_out_valid
);

    logic [data_width-1:0] chan_q [n_channels];
    logic [full_width-1:0] acc_q, acc_d;
    logic [data_width-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [data_width-1:0] acc_rd_q, acc_rd_d;
    logic [data_width-1:0] sample_q;
    logic                  sample_valid_q;

    logic [full_width:0]              acc_sum;
    logic [full_width-1:0]            acc_sat;
    logic signed [full_width-1:0]     acc_shifted;
    logic [full_width-data_width:0]   acc_upper;

    // One guard bit on the sum: guard and MSB disagreeing means the add overflowed.
    always_comb begin
        acc_sum = {acc_q[full_width-1], acc_q}
                + {accumulator_write_val[full_width-1], accumulator_write_val};
        if (acc_sum[full_width] != acc_sum[full_width-1])
            acc_sat = {acc_sum[full_width], {(full_width-1){~acc_sum[full_width]}}};
        else
            acc_sat = acc_sum[full_width-1:0];

        acc_d = acc_q;
        if (accumulator_write_enable)
            acc_d = accumulator_add_enable ? acc_sat : accumulator_write_val;
    end

    // Readout is taken from the next accumulator value so same-cycle updates show through.
    always_comb begin
        acc_shifted = $signed(acc_d) >>> acc_shift;
        acc_upper   = acc_shifted[full_width-1:data_width-1];
        if ((&acc_upper) || !(|acc_upper))
            acc_rd_d = acc_shifted[data_width-1:0];
        else
            acc_rd_d = {acc_shifted[full_width-1], {(data_width-1){~acc_shifted[full_width-1]}}};
    end

    always_comb begin
        rd_a_d = chan_q[read_addr_a];
        rd_b_d = chan_q[read_addr_b];
        if (channel_write_enable && channel_write_addr == read_addr_a)
            rd_a_d = channel_write_val;
        if (channel_write_enable && channel_write_addr == read_addr_b)
            rd_b_d = channel_write_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < n_channels; i++)
                chan_q[i] <= '0;
            acc_q          <= '0;
            rd_a_q         <= '0;
            rd_b_q         <= '0;
            acc_rd_q       <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            // The strobe must drop even when enable falls right after a tick.
            sample_valid_q <= enable && sample_tick;
            if (enable) begin
                if (channel_write_enable)
                    chan_q[channel_write_addr] <= channel_write_val;
                acc_q    <= acc_d;
                rd_a_q   <= rd_a_d;
                rd_b_q   <= rd_b_d;
                acc_rd_q <= acc_rd_d;
                if (sample_tick)
                    sample_q <= chan_q[out_channel];
            end
        end
    end

    assign read_val_a       = rd_a_q;
    assign read_val_b       = rd_b_q;
    assign acc_read_val     = acc_rd_q;
    assign sample_out       = sample_q;
    assign sample_out_valid = sample_valid_q;

endmodule
